// File: rtl/svk_axi_arb_pkg.sv
// Shared types and helpers for the AXI write-path arbiter.
// Imported by svk_axi_rr_arbiter and svk_axi_wr_arb.
package svk_axi_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/svk_axi_rr_arbiter.sv
// Round-robin arbiter: first request at or after i_ptr wins.
// Produces both a one-hot grant and the winning index.
module svk_axi_rr_arbiter
    import svk_axi_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    int   w_j;
    logic w_found;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int k = 0; k < N; k++) begin
            w_j = (int'(i_ptr) + k) % N;
            if (!w_found && i_req[w_j]) begin
                w_found    = 1'b1;
                o_gnt[w_j] = 1'b1;
                o_idx      = IW'(w_j);
            end
        end
    end

    assign o_any = w_found;

endmodule

// File: rtl/svk_axi_wr_arb.sv
// AXI write arbiter: NM masters onto one slave, W follows AW grant order.
// Optional SVK_AXI_WR_ARB_QOS_EN: highest AWQOS wins, ties round-robin.
module svk_axi_wr_arb
    import svk_axi_arb_pkg::*;
#(
    parameter int NM    = 4,
    parameter int IDW   = 4,
    parameter int AW    = 32,
    parameter int DW    = 64,
    parameter int DEPTH = 8,
    parameter int MIW   = clog2(NM)
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [NM-1:0]        m_awvalid,
    output logic [NM-1:0]        m_awready,
    input  logic [NM*IDW-1:0]    m_awid,
    input  logic [NM*AW-1:0]     m_awaddr,
    input  logic [NM*8-1:0]      m_awlen,
    input  logic [NM*3-1:0]      m_awsize,
    input  logic [NM*2-1:0]      m_awburst,
    input  logic [NM*4-1:0]      m_awqos,
    input  logic [NM-1:0]        m_wvalid,
    output logic [NM-1:0]        m_wready,
    input  logic [NM*DW-1:0]     m_wdata,
    input  logic [NM*DW/8-1:0]   m_wstrb,
    input  logic [NM-1:0]        m_wlast,
    output logic [NM-1:0]        m_bvalid,
    input  logic [NM-1:0]        m_bready,
    output logic [NM*IDW-1:0]    m_bid,
    output logic [NM*2-1:0]      m_bresp,
    output logic                 s_awvalid,
    input  logic                 s_awready,
    output logic [IDW+MIW-1:0]   s_awid,
    output logic [AW-1:0]        s_awaddr,
    output logic [7:0]           s_awlen,
    output logic [2:0]           s_awsize,
    output logic [1:0]           s_awburst,
    output logic [3:0]           s_awqos,
    output logic                 s_wvalid,
    input  logic                 s_wready,
    output logic [DW-1:0]        s_wdata,
    output logic [DW/8-1:0]      s_wstrb,
    output logic                 s_wlast,
    input  logic                 s_bvalid,
    output logic                 s_bready,
    input  logic [IDW+MIW-1:0]   s_bid,
    input  logic [1:0]           s_bresp
);

    localparam int SIW = IDW + MIW;
    localparam int SW  = DW / 8;
    localparam int FAW = clog2(DEPTH);
    localparam int CW  = FAW + 1;

    arb_state_e       r_state;
    logic [MIW-1:0]   r_gnt;
    logic [MIW-1:0]   r_ptr;
    logic             r_awvalid;
    logic [SIW-1:0]   r_awid;
    logic [AW-1:0]    r_awaddr;
    logic [7:0]       r_awlen;
    logic [2:0]       r_awsize;
    logic [1:0]       r_awburst;
    logic [3:0]       r_awqos;

    logic [MIW-1:0]   r_fifo [DEPTH];
    logic [FAW-1:0]   r_wptr;
    logic [FAW-1:0]   r_rptr;
    logic [CW-1:0]    r_count;

    logic [NM-1:0]    w_req;
    logic [NM-1:0]    w_arb_gnt;
    logic [MIW-1:0]   w_arb_idx;
    logic             w_arb_any;
    logic             w_full;
    logic             w_empty;
    logic             w_aw_hs;
    logic             w_w_hs;
    logic [MIW-1:0]   w_head;
    logic [MIW-1:0]   w_bsel;
    logic [MIW-1:0]   w_ptr_nxt;

`ifdef SVK_AXI_WR_ARB_QOS_EN
    logic [3:0] w_maxqos;

    // Only masters at the highest valid QoS level compete.
    always_comb begin
        w_maxqos = '0;
        w_req    = '0;
        for (int i = 0; i < NM; i++) begin
            if (m_awvalid[i] && (m_awqos[i*4 +: 4] > w_maxqos)) begin
                w_maxqos = m_awqos[i*4 +: 4];
            end
        end
        for (int i = 0; i < NM; i++) begin
            w_req[i] = m_awvalid[i] && (m_awqos[i*4 +: 4] == w_maxqos);
        end
    end
`else
    assign w_req = m_awvalid;
`endif

    svk_axi_rr_arbiter #(
        .N  (NM),
        .IW (MIW)
    ) u_rr (
        .i_req (w_req),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx),
        .o_any (w_arb_any)
    );

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_aw_hs   = (r_state == BUSY) && s_awready;
    assign w_head    = r_fifo[r_rptr];
    assign w_ptr_nxt = (r_gnt == MIW'(NM - 1)) ? '0 : r_gnt + MIW'(1);

    // r_ptr is the first master to consider, so master 0 leads after reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_ptr     <= '0;
            r_awvalid <= 1'b0;
            r_awid    <= '0;
            r_awaddr  <= '0;
            r_awlen   <= '0;
            r_awsize  <= '0;
            r_awburst <= '0;
            r_awqos   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_arb_any && !w_full) begin
                        r_state   <= BUSY;
                        r_gnt     <= w_arb_idx;
                        r_awvalid <= 1'b1;
                        r_awid    <= {w_arb_idx,
                                      m_awid[int'(w_arb_idx)*IDW +: IDW]};
                        r_awaddr  <= m_awaddr[int'(w_arb_idx)*AW +: AW];
                        r_awlen   <= m_awlen[int'(w_arb_idx)*8 +: 8];
                        r_awsize  <= m_awsize[int'(w_arb_idx)*3 +: 3];
                        r_awburst <= m_awburst[int'(w_arb_idx)*2 +: 2];
                        r_awqos   <= m_awqos[int'(w_arb_idx)*4 +: 4];
                    end
                end
                BUSY: begin
                    if (s_awready) begin
                        r_state   <= IDLE;
                        r_awvalid <= 1'b0;
                        r_ptr     <= w_ptr_nxt;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            if (w_aw_hs) begin
                r_fifo[r_wptr] <= r_gnt;
                r_wptr         <= r_wptr + FAW'(1);
            end
            if (w_w_hs) begin
                r_rptr <= r_rptr + FAW'(1);
            end
            unique case ({w_aw_hs, w_w_hs})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign s_awvalid = r_awvalid;
    assign s_awid    = r_awid;
    assign s_awaddr  = r_awaddr;
    assign s_awlen   = r_awlen;
    assign s_awsize  = r_awsize;
    assign s_awburst = r_awburst;
    assign s_awqos   = r_awqos;

    always_comb begin
        m_awready = '0;
        if (r_state == BUSY) begin
            m_awready[r_gnt] = s_awready;
        end
    end

    always_comb begin
        s_wvalid = 1'b0;
        s_wdata  = '0;
        s_wstrb  = '0;
        s_wlast  = 1'b0;
        m_wready = '0;
        if (!w_empty) begin
            s_wvalid         = m_wvalid[w_head];
            s_wdata          = m_wdata[int'(w_head)*DW +: DW];
            s_wstrb          = m_wstrb[int'(w_head)*SW +: SW];
            s_wlast          = m_wlast[w_head];
            m_wready[w_head] = s_wready;
        end
    end

    assign w_w_hs = s_wvalid && s_wready && s_wlast;
    assign w_bsel = s_bid[IDW +: MIW];

    // An out-of-range prefix has no owner; swallow it so the slave never hangs.
    always_comb begin
        m_bvalid = '0;
        s_bready = 1'b1;
        for (int i = 0; i < NM; i++) begin
            m_bid[i*IDW +: IDW] = s_bid[IDW-1:0];
            m_bresp[i*2 +: 2]   = s_bresp;
        end
        for (int i = 0; i < NM; i++) begin
            if (int'(w_bsel) == i) begin
                m_bvalid[i] = s_bvalid;
                s_bready    = m_bready[i];
            end
        end
    end

endmodule
